uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
Second-generation UART transmitter with a parametrised data width and an internal transmit FIFO.
- Runtime-configurable baud divisor, parity mode (none/even/odd) and stop-bit count.
- Upstream logic pushes bytes through a valid/ready handshake. The block serialises them LSB-first onto uart_txd with no idle gap between queued frames.
- Sits between a bus-facing register block and the TX pad.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9).
FIFO_DEPTH, 4, transmit FIFO entries (power of 2, >=2).
DIV_W, 16, width of cfg_div and of the internal cycle counter.

Ports:
clk  in  1  system clock.
resetn  in  1  asynchronous active-low reset.
tx_valid  in  1  upstream data valid.
tx_ready  out  1  FIFO can accept; equals (fifo_level != FIFO_DEPTH).
tx_data  in  DATA_BITS  payload to queue.
cfg_div  in  DIV_W  clk cycles per UART bit; values 0 and 1 are treated as 2.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
cfg_stop2  in  1  0: one stop bit, 1: two stop bits.
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
tx_busy  out  1  FIFO non-empty or frame in progress.
uart_txd  out  1  serial output, registered.

Behaviour:
Reset and handshake:
- Reset (async, active-low) values: uart_txd=1, FSM=IDLE, FIFO empty, fifo_level=0, tx_busy=0, tx_ready=1.
- Push: tx_valid && tx_ready at a rising edge writes tx_data. No push is accepted when full, even if a pop occurs in the same cycle.

Frame start:
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with FIFO non-empty at an edge:
  - pop the head into the shift register;
  - latch cfg_div (clamped), cfg_parity and cfg_stop2 into frame registers;
  - compute the parity bit from the popped word;
  - go to START and drive uart_txd<=0 at that same edge.
- First-word latency: push at edge k, start bit driven at edge k+1.

Bit timing and sequencing:
- Every bit lasts exactly div_latched clk cycles, counted by a DIV_W-bit counter from 0 to div_latched-1.
- START -> DATA after one bit time.
- DATA: DATA_BITS bits, LSB first, shift right on each bit boundary.
- DATA -> PARITY if parity is enabled, else -> STOP.
- PARITY bit: even = XOR of data bits; odd = its inverse.
- STOP: uart_txd=1 for 1 or 2 bit times, per the latched cfg_stop2.
- Frame length = (1 + DATA_BITS + P + S) * div_latched cycles, where P = 1 if parity is enabled else 0, and S = 2 if cfg_stop2 else 1.

End of frame:
- At the final STOP cycle, if the FIFO is non-empty, pop and go directly to START: uart_txd goes 0 on the next edge with no extra idle cycle.
- Otherwise go to IDLE, keeping uart_txd=1.

Status and configuration rules:
- tx_busy = (state != IDLE) || (fifo_level != 0). It goes low in the cycle after the last stop bit completes with the FIFO empty.
- Changes to the cfg_* inputs mid-frame do not affect the current frame; they take effect at the next pop.

Reset mid-frame:
- uart_txd returns to 1 immediately (asynchronously).
- Queued data is discarded and the counters are cleared.
- After reset release, no partial frame resumes.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - parity_t enum {PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10};
  - constant MIN_DIV=2.
- Sub-module uart_sync_fifo (params WIDTH, DEPTH; ports push/pop/wdata/rdata/level/full/empty; async active-low reset). It is reused later by the RX side.
- Top module holds the FSM, bit counter, cycle counter, shift register and txd register.

Test Plan:
1. div=4, parity none, stop1; push 0xA5 → uart_txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; frame = 40 cycles; tx_busy drops the cycle after.
2. div=4, parity even, push 0x07 → parity bit 1 after bit 7. Parity odd, push 0x07 → parity bit 0. 11-bit frames of 44 cycles.
3. div=3, stop2, push 0x00, 0xFF, 0x55 back-to-back → three contiguous 11-bit frames (33 cycles each); each start bit falls immediately after the previous second stop bit; total 99 busy cycles.
4. div=100, FIFO_DEPTH=4, hold tx_valid for 6 cycles → 5 words accepted (1 popped, 4 queued); fifo_level=4; tx_ready=0 until the first frame ends and the next pop occurs.
5. div=4, push 2 words; set cfg_div=8 during the first frame's data bits → first frame keeps 4-cycle bits, second frame uses 8-cycle bits.
6. Assert resetn low during DATA bit 3 with 2 words queued → uart_txd=1 before the next clk edge; after release fifo_level=0, tx_busy=0, line idle-high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  // Smallest usable bit period in clk cycles; smaller divisors are clamped up.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry.
// Push while full and pop while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, configurable divisor,
// parity and stop bits. Back-to-back frames run with no idle gap.
//
//   state  | meaning
//   IDLE   | line high, waiting for a queued word
//   START  | driving the start bit (0)
//   DATA   | shifting out DATA_BITS payload bits, LSB first
//   PARITY | driving the latched parity bit
//   STOP   | line high for one or two bit times
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          uart_txd
);

  localparam int BW = $clog2(DATA_BITS + 1);

  tx_state_t            state, state_d;
  logic [DIV_W-1:0]     cnt, div_lat, div_clamped;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg, fifo_rdata;
  logic                 par_bit, par_en, stop2_lat;
  logic                 fifo_full, fifo_empty;
  logic                 bit_end, last_data, last_stop, load, txd_d;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_valid && tx_ready),
    .pop    (load),
    .wdata  (tx_data),
    .rdata  (fifo_rdata),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign tx_ready    = !fifo_full;
  assign tx_busy     = (state != IDLE) || (fifo_level != '0);
  assign div_clamped = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
  assign bit_end     = (cnt == div_lat - DIV_W'(1));
  assign last_data   = (bit_idx == BW'(DATA_BITS - 1));
  assign last_stop   = (bit_idx == (stop2_lat ? BW'(1) : BW'(0)));
  // A new frame starts from IDLE or straight out of the final stop cycle.
  assign load        = !fifo_empty &&
                       ((state == IDLE) || (state == STOP && bit_end && last_stop));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && last_data) state_d = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end && last_stop) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Next line value; the line only changes on a frame load or a bit boundary.
  always_comb begin
    txd_d = uart_txd;
    if (load) begin
      txd_d = 1'b0;
    end else if (bit_end) begin
      case (state)
        START:   txd_d = shreg[0];
        DATA:    txd_d = last_data ? (par_en ? par_bit : 1'b1) : shreg[1];
        default: txd_d = 1'b1;
      endcase
    end
  end

  // Registered serial output, idle-high out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) uart_txd <= 1'b1;
    else         uart_txd <= txd_d;
  end

  // Frame datapath: config latched at pop, cycle and bit counters, shifter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      div_lat   <= DIV_W'(MIN_DIV);
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2_lat <= 1'b0;
    end else if (load) begin
      shreg     <= fifo_rdata;
      div_lat   <= div_clamped;
      par_en    <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      par_bit   <= (cfg_parity == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      stop2_lat <= cfg_stop2;
      cnt       <= '0;
      bit_idx   <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        cnt <= '0;
        case (state)
          DATA: begin
            if (last_data) begin
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              shreg   <= shreg >> 1;
            end
          end
          STOP:    bit_idx <= bit_idx + BW'(1);
          default: bit_idx <= '0;
        endcase
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a frame scoreboard and line monitor.
module tb_uart_tx_buffered;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        tx_ready;
  logic [2:0]  fifo_level;
  logic        tx_busy;
  logic        uart_txd;

  uart_tx_buffered #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .fifo_level (fifo_level),
    .tx_busy    (tx_busy),
    .uart_txd   (uart_txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         par;    // 0 none, 1 even, 2 odd
    bit         stop2;
    int         div;
  } exp_t;

  exp_t sb[$];
  int   start_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_busy = 0;
  int   push_cyc = 0;
  bit   mon_en = 1'b1;
  bit   mon_busy = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (tx_busy === 1'b1) last_busy = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: on each start bit, pop the expected frame and check every cycle.
  initial begin : monitor
    exp_t e;
    logic bits [16];
    int   nb;
    forever begin
      @(negedge clk);
      if (mon_en && resetn === 1'b1 && uart_txd === 1'b0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_start: observed=frame expected=no_frame at cycle %0d", cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1 + i] = e.data[i];
          nb = 9;
          if (e.par != 0) begin
            bits[nb] = (e.par == 1) ? ^e.data : ~^e.data;
            nb++;
          end
          bits[nb] = 1'b1;
          nb++;
          if (e.stop2) begin
            bits[nb] = 1'b1;
            nb++;
          end
          start_cyc.push_back(cyc);
          mon_busy = 1'b1;
          for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < e.div; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              chk($sformatf("txd_f%0d_b%0d_c%0d", start_cyc.size() - 1, b, c),
                  {31'd0, uart_txd}, {31'd0, bits[b]});
            end
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; presents one word for exactly one rising edge.
  task automatic push_word(input logic [7:0] d, input int div, input int par, input bit s2);
    exp_t e;
    int n = 0;
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, tx_ready}, 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    push_cyc = cyc + 1;
    e.data = d; e.par = par; e.stop2 = s2; e.div = div;
    if (mon_en) sb.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (start_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frames_started", start_cyc.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((tx_busy !== 1'b0 || mon_busy || sb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({"idle_", tag}, {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int s;
    int k;
    int accepted;
    int ready_hi;
    int hi;
    logic [7:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, uart_txd}, 32'd1);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // 1: div 4, no parity, one stop bit, 0xA5
    cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    push_word(8'hA5, 4, 0, 0);
    wait_frames(1, 50);
    chk("t1_latency", start_cyc[0], push_cyc + 1);
    wait_idle("t1", 200);
    chk("t1_busy_span", last_busy - start_cyc[0] + 1, 40);

    // 2: even then odd parity on 0x07, 44-cycle frames
    cfg_parity = 2'b01;
    push_word(8'h07, 4, 1, 0);
    wait_idle("t2e", 200);
    chk("t2_even_span", last_busy - start_cyc[1] + 1, 44);
    cfg_parity = 2'b10;
    push_word(8'h07, 4, 2, 0);
    wait_idle("t2o", 200);
    chk("t2_odd_span", last_busy - start_cyc[2] + 1, 44);

    // 3: div 3, two stop bits, three contiguous frames
    cfg_parity = 2'b00; cfg_stop2 = 1'b1; cfg_div = 16'd3;
    push_word(8'h00, 3, 0, 1);
    push_word(8'hFF, 3, 0, 1);
    push_word(8'h55, 3, 0, 1);
    wait_idle("t3", 400);
    chk("t3_gap1", start_cyc[4] - start_cyc[3], 33);
    chk("t3_gap2", start_cyc[5] - start_cyc[4], 33);
    chk("t3_busy_span", last_busy - start_cyc[3] + 1, 99);

    // 4: div 100, tx_valid held 6 cycles, FIFO fills
    cfg_div = 16'd100; cfg_stop2 = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      d = 8'h10 + 8'(i);
      tx_valid = 1'b1;
      tx_data  = d;
      if (tx_ready === 1'b1) begin
        accepted++;
        sb.push_back('{d, 0, 1'b0, 100});
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("t4_accepted", accepted, 5);
    chk("t4_level_full", {29'd0, fifo_level}, 32'd4);
    chk("t4_ready_low", {31'd0, tx_ready}, 32'd0);
    wait_frames(7, 20);
    s = start_cyc[6];
    k = 0;
    ready_hi = 0;
    while (cyc < s + 999 && k < 2000) begin
      if (tx_ready !== 1'b0) ready_hi++;
      @(negedge clk);
      k++;
    end
    chk("t4_ready_held_low", ready_hi, 0);
    chk("t4_ready_last_cycle", {31'd0, tx_ready}, 32'd0);
    chk("t4_level_last_cycle", {29'd0, fifo_level}, 32'd4);
    @(negedge clk);
    chk("t4_ready_after_pop", {31'd0, tx_ready}, 32'd1);
    chk("t4_level_after_pop", {29'd0, fifo_level}, 32'd3);
    wait_idle("t4", 6000);

    // 5: divisor change mid-frame only affects the next frame
    cfg_div = 16'd4;
    push_word(8'hAA, 4, 0, 0);
    push_word(8'h3C, 8, 0, 0);
    wait_frames(12, 50);
    s = start_cyc[11];
    k = 0;
    while (cyc < s + 8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    cfg_div = 16'd8;
    wait_idle("t5", 400);
    chk("t5_first_len", start_cyc[12] - start_cyc[11], 40);
    chk("t5_second_span", last_busy - start_cyc[12] + 1, 80);

    // 6: reset during data bit 3 with two words queued
    mon_en = 1'b0;
    cfg_div = 16'd4;
    push_word(8'h00, 4, 0, 0);
    s = push_cyc + 1;
    push_word(8'h00, 4, 0, 0);
    push_word(8'h00, 4, 0, 0);
    k = 0;
    while (cyc < s + 16 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_bit3_low", {31'd0, uart_txd}, 32'd0);
    chk("t6_level_queued", {29'd0, fifo_level}, 32'd2);
    resetn = 1'b0;
    #1;
    chk("t6_async_txd", {31'd0, uart_txd}, 32'd1);
    chk("t6_async_level", {29'd0, fifo_level}, 32'd0);
    chk("t6_async_busy", {31'd0, tx_busy}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_txd === 1'b1 && tx_busy === 1'b0 && fifo_level === 3'd0) hi++;
    end
    chk("t6_idle_after_release", hi, 20);
    mon_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
